iz_param_loader: RTL

- Byte-serial configuration loader for the Izhikevich neuron datapath.
- Receives a framed parameter stream on an 8-bit bus and assembles the four 16-bit parameters (a, b, c, d) in shadow registers.
- Commits all four parameters to the neuron atomically and drives its params_ready qualifier.
- Sits between the external config pins and the neuron core; the neuron freezes its integration while params_ready is low.

---
 rtl/iz_param_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/iz_param_loader.sv
// Byte-serial loader that assembles Izhikevich a/b/c/d parameters and commits them atomically.
// Define IZ_PARAM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte per frame.
module iz_param_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [15:0] DEF_A          = 16'd1,
    parameter logic [15:0] DEF_B          = 16'd13,
    parameter logic [15:0] DEF_C          = 16'hEFC0,
    parameter logic [15:0] DEF_D          = 16'd512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        load_busy,
    output logic        load_error,
    output logic [7:0]  frame_count
);
    localparam int unsigned   TmoW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

`ifdef IZ_PARAM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StCollect, StCommit, StCheckWait} state_e;
`else
    typedef enum logic [1:0] {StIdle, StCollect, StCommit} state_e;
`endif

    state_e          state_q, state_d;
    logic [2:0]      idx_q;
    logic [TmoW-1:0] tmo_q;
    logic [7:0]      shadow_q [8];
    logic            valid_q;
    logic [15:0]     param_a_q, param_b_q, param_c_q, param_d_q;
    logic            params_ready_q, load_busy_q, load_error_q;
    logic [7:0]      frame_count_q;

    logic accept, tmo_hit, in_frame;
    logic do_start, do_store, do_commit, do_abort;

`ifdef IZ_PARAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    always_comb begin
        sum = 8'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + shadow_q[i];
        end
    end
    assign data_ready = load_en &&
        (state_q == StIdle || state_q == StCollect || state_q == StCheckWait);
`else
    assign data_ready = load_en && (state_q == StIdle || state_q == StCollect);
`endif

    assign accept  = data_valid && data_ready;
    assign tmo_hit = (tmo_q == TmoMax);

    always_comb begin
        state_d   = state_q;
        in_frame  = 1'b0;
        do_start  = 1'b0;
        do_store  = 1'b0;
        do_commit = 1'b0;
        do_abort  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && data_in == SYNC_BYTE) begin
                    do_start = 1'b1;
                    state_d  = StCollect;
                end
            end
            StCollect: begin
                in_frame = 1'b1;
                if (accept) begin
                    do_store = 1'b1;
                    if (idx_q == 3'd7) begin
`ifdef IZ_PARAM_LOADER_CHECKSUM_EN
                        state_d = StCheckWait;
`else
                        state_d = StCommit;
`endif
                    end
                end else if (!load_en || tmo_hit) begin
                    do_abort = 1'b1;
                    state_d  = StIdle;
                end
            end
`ifdef IZ_PARAM_LOADER_CHECKSUM_EN
            StCheckWait: begin
                in_frame = 1'b1;
                if (accept) begin
                    if (data_in == sum) begin
                        state_d = StCommit;
                    end else begin
                        do_abort = 1'b1;
                        state_d  = StIdle;
                    end
                end else if (!load_en || tmo_hit) begin
                    do_abort = 1'b1;
                    state_d  = StIdle;
                end
            end
`endif
            StCommit: begin
                do_commit = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            idx_q          <= 3'd0;
            tmo_q          <= '0;
            for (int i = 0; i < 8; i++) shadow_q[i] <= 8'd0;
            valid_q        <= 1'b0;
            param_a_q      <= DEF_A;
            param_b_q      <= DEF_B;
            param_c_q      <= DEF_C;
            param_d_q      <= DEF_D;
            params_ready_q <= 1'b0;
            load_busy_q    <= 1'b0;
            load_error_q   <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            load_error_q <= do_abort;
            // Idle cycles are only counted while a frame is open; saturate rather than wrap.
            if (!in_frame || accept || do_abort) begin
                tmo_q <= '0;
            end else if (!tmo_hit) begin
                tmo_q <= tmo_q + TmoW'(1);
            end
            if (do_start) begin
                idx_q          <= 3'd0;
                params_ready_q <= 1'b0;
                load_busy_q    <= 1'b1;
            end
            if (do_store) begin
                shadow_q[idx_q] <= data_in;
                idx_q           <= idx_q + 3'd1;
            end
            if (do_commit) begin
                param_a_q      <= {shadow_q[1], shadow_q[0]};
                param_b_q      <= {shadow_q[3], shadow_q[2]};
                param_c_q      <= {shadow_q[5], shadow_q[4]};
                param_d_q      <= {shadow_q[7], shadow_q[6]};
                params_ready_q <= 1'b1;
                valid_q        <= 1'b1;
                frame_count_q  <= frame_count_q + 8'd1;
                load_busy_q    <= 1'b0;
            end
            if (do_abort) begin
                load_busy_q    <= 1'b0;
                params_ready_q <= valid_q;
            end
        end
    end

    assign param_a      = param_a_q;
    assign param_b      = param_b_q;
    assign param_c      = param_c_q;
    assign param_d      = param_d_q;
    assign params_ready = params_ready_q;
    assign load_busy    = load_busy_q;
    assign load_error   = load_error_q;
    assign frame_count  = frame_count_q;

endmodule
